// File: rtl/dodge_gfx_pkg.sv
// Shared graphics constants and types for the DODGE sprite draw path (160x120, 3-bit colour).
package dodge_gfx_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int DIM_W    = 5;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] COL_GREEN = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } sde_state_t;

    // True when a carry-extended pixel address falls outside the visible screen.
    function automatic logic is_offscreen(input logic [X_W:0] px, input logic [Y_W:0] py);
        return (px >= (X_W+1)'(SCREEN_W)) || (py >= (Y_W+1)'(SCREEN_H));
    endfunction

endpackage

// File: rtl/sprite_draw_engine_raster_scan_counter.sv
// Row-major column/row scan counter with programmable limits; exposes the next
// position and a last flag for the position currently being presented.
module raster_scan_counter
    import dodge_gfx_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    input  logic [X_W-1:0] w_lim,
    input  logic [Y_W-1:0] h_lim,
    output logic [X_W-1:0] next_col,
    output logic [Y_W-1:0] next_row,
    output logic           last
);

    logic [X_W-1:0] col_r;
    logic [Y_W-1:0] row_r;
    logic           col_end_s;

    assign col_end_s = (col_r == (w_lim - X_W'(1)));
    assign last      = col_end_s && (row_r == (h_lim - Y_W'(1)));

    // Next scan position: wrap column at the width limit and step the row.
    always_comb begin
        next_col = col_r;
        next_row = row_r;
        if (col_end_s) begin
            next_col = {X_W{1'b0}};
            next_row = row_r + Y_W'(1);
        end else begin
            next_col = col_r + X_W'(1);
            next_row = row_r;
        end
    end

    // Position register; cleared at request accept, stepped once per pixel.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col_r <= {X_W{1'b0}};
            row_r <= {Y_W{1'b0}};
        end else if (advance) begin
            col_r <= next_col;
            row_r <= next_row;
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

endmodule

// File: rtl/sprite_draw_engine.sv
// Rectangle/full-screen rasteriser feeding vga_adapter one pixel per clock.
// Optional off-screen clipping is enabled by defining SPRITE_DRAW_CLIP_EN.
module sprite_draw_engine
    import dodge_gfx_pkg::*;
(
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_clear,
    input  logic [X_W-1:0]      req_x,
    input  logic [Y_W-1:0]      req_y,
    input  logic [DIM_W-1:0]    req_w,
    input  logic [DIM_W-1:0]    req_h,
    input  logic [COLOUR_W-1:0] req_colour,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    sde_state_t          state_r, next_state_s;
    logic [X_W-1:0]      x0_r, x_r, x_next_s, base_x_s, off_x_s, pix_x_s, w_lim_s, next_col_s;
    logic [Y_W-1:0]      y0_r, y_r, y_next_s, base_y_s, off_y_s, pix_y_s, h_lim_s, next_row_s;
    logic [DIM_W-1:0]    w_r, h_r;
    logic [COLOUR_W-1:0] colour_r, colour_next_s;
    logic                plot_r, plot_next_s, done_r, done_next_s, busy_r, req_ready_r;
    logic                accept_s, latch_s, cnt_clear_s, cnt_adv_s, cnt_last_s, clip_s;

    assign accept_s  = req_valid && req_ready_r;
    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign x         = x_r;
    assign y         = y_r;
    assign colour    = colour_r;
    assign plot      = plot_r;

    assign w_lim_s = (state_r == CLEAR) ? X_W'(SCREEN_W) : X_W'(w_r);
    assign h_lim_s = (state_r == CLEAR) ? Y_W'(SCREEN_H) : Y_W'(h_r);

    raster_scan_counter u_scan (
        .clk      (CLOCK_50),
        .reset    (reset),
        .clear    (cnt_clear_s),
        .advance  (cnt_adv_s),
        .w_lim    (w_lim_s),
        .h_lim    (h_lim_s),
        .next_col (next_col_s),
        .next_row (next_row_s),
        .last     (cnt_last_s)
    );

    // In IDLE the first pixel comes straight from the request payload, later ones from the latched origin.
    always_comb begin
        if (state_r == IDLE) begin
            base_x_s = req_x;
            base_y_s = req_y;
            off_x_s  = {X_W{1'b0}};
            off_y_s  = {Y_W{1'b0}};
        end else begin
            base_x_s = x0_r;
            base_y_s = y0_r;
            off_x_s  = next_col_s;
            off_y_s  = next_row_s;
        end
    end

`ifdef SPRITE_DRAW_CLIP_EN
    logic [X_W:0] pix_x_wide_s;
    logic [Y_W:0] pix_y_wide_s;
    assign pix_x_wide_s = {1'b0, base_x_s} + {1'b0, off_x_s};
    assign pix_y_wide_s = {1'b0, base_y_s} + {1'b0, off_y_s};
    assign pix_x_s      = pix_x_wide_s[X_W-1:0];
    assign pix_y_s      = pix_y_wide_s[Y_W-1:0];
    assign clip_s       = is_offscreen(pix_x_wide_s, pix_y_wide_s);
`else
    assign pix_x_s = base_x_s + off_x_s;
    assign pix_y_s = base_y_s + off_y_s;
    assign clip_s  = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        next_state_s  = state_r;
        x_next_s      = x_r;
        y_next_s      = y_r;
        colour_next_s = colour_r;
        plot_next_s   = 1'b0;
        done_next_s   = 1'b0;
        latch_s       = 1'b0;
        cnt_clear_s   = 1'b0;
        cnt_adv_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    latch_s       = 1'b1;
                    cnt_clear_s   = 1'b1;
                    colour_next_s = req_colour;
                    if (req_clear) begin
                        next_state_s = CLEAR;
                        x_next_s     = {X_W{1'b0}};
                        y_next_s     = {Y_W{1'b0}};
                        plot_next_s  = 1'b1;
                    end else if ((req_w == {DIM_W{1'b0}}) || (req_h == {DIM_W{1'b0}})) begin
                        next_state_s = DONE;
                        done_next_s  = 1'b1;
                    end else begin
                        next_state_s = DRAW;
                        x_next_s     = pix_x_s;
                        y_next_s     = pix_y_s;
                        plot_next_s  = !clip_s;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            DRAW, CLEAR: begin
                if (cnt_last_s) begin
                    next_state_s = DONE;
                    done_next_s  = 1'b1;
                end else begin
                    cnt_adv_s   = 1'b1;
                    x_next_s    = pix_x_s;
                    y_next_s    = pix_y_s;
                    plot_next_s = !clip_s;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, request latch and registered pixel/handshake outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r     <= IDLE;
            x0_r        <= {X_W{1'b0}};
            y0_r        <= {Y_W{1'b0}};
            w_r         <= {DIM_W{1'b0}};
            h_r         <= {DIM_W{1'b0}};
            x_r         <= {X_W{1'b0}};
            y_r         <= {Y_W{1'b0}};
            colour_r    <= {COLOUR_W{1'b0}};
            plot_r      <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            x_r         <= x_next_s;
            y_r         <= y_next_s;
            colour_r    <= colour_next_s;
            plot_r      <= plot_next_s;
            done_r      <= done_next_s;
            busy_r      <= (next_state_s != IDLE);
            req_ready_r <= (next_state_s == IDLE);
            if (latch_s) begin
                x0_r <= req_clear ? {X_W{1'b0}} : req_x;
                y0_r <= req_clear ? {Y_W{1'b0}} : req_y;
                w_r  <= req_w;
                h_r  <= req_h;
            end else begin
                x0_r <= x0_r;
                y0_r <= y0_r;
                w_r  <= w_r;
                h_r  <= h_r;
            end
        end
    end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Table-driven bench for sprite_draw_engine plus hand sequences for reset abort and held requests.
module tb_sprite_draw_engine;
    import dodge_gfx_pkg::*;

    logic                CLOCK_50 = 1'b0;
    logic                reset;
    logic                req_valid, req_clear;
    logic [X_W-1:0]      req_x;
    logic [Y_W-1:0]      req_y;
    logic [DIM_W-1:0]    req_w, req_h;
    logic [COLOUR_W-1:0] req_colour;
    logic                req_ready, busy, done, plot;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;

    int checks = 0;
    int errors = 0;

    sprite_draw_engine dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_clear  (req_clear),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .busy       (busy),
        .done       (done),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int px, py, w, h, col, clr;
        int n, lx, ly;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Drive a request and return one cycle after the accepting edge.
    task automatic issue(input int px, py, w, h, col, clr);
        int k = 0;
        req_x      = 8'(px);
        req_y      = 7'(py);
        req_w      = 5'(w);
        req_h      = 5'(h);
        req_colour = 3'(col);
        req_clear  = 1'(clr);
        req_valid  = 1'b1;
        while (!req_ready && k < 100) begin
            tick();
            k++;
        end
        chk("ready_wait", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Expect nx*ny consecutive pixel cycles in row-major order, then done, then ready.
    task automatic expect_stream(input int bx, by, nx, ny, col, exp_n, exp_lx, exp_ly);
        int n = 0;
        int lx = -1;
        int ly = -1;
        for (int r = 0; r < ny; r++) begin
            for (int c = 0; c < nx; c++) begin
                int ex = (bx + c) % 256;
                int ey = (by + r) % 128;
                logic ep;
`ifdef SPRITE_DRAW_CLIP_EN
                ep = ((bx + c) < 160) && ((by + r) < 120);
`else
                ep = 1'b1;
`endif
                if (ep) begin
                    chk("pixel", {10'b0, plot, x, y, colour, busy, done, req_ready},
                        {10'b0, 1'b1, 8'(ex), 7'(ey), 3'(col), 1'b1, 1'b0, 1'b0});
                    n++;
                    lx = ex;
                    ly = ey;
                end else begin
                    chk("clipped", {28'b0, plot, busy, done, req_ready}, {28'b0, 4'b0100});
                end
                tick();
            end
        end
        chk("done_pulse", {28'b0, done, plot, busy, req_ready}, {28'b0, 4'b1010});
        tick();
        chk("idle_after", {28'b0, done, plot, busy, req_ready}, {28'b0, 4'b0001});
        chk("pixel_count", n, exp_n);
        if (exp_n > 0) begin
            chk("last_x", lx, exp_lx);
            chk("last_y", ly, exp_ly);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{80, 50, 4, 4, 2, 0, 16, 83, 53};
        vt[1] = '{10, 10, 0, 5, 3, 0, 0, 0, 0};
        vt[2] = '{10, 20, 16, 1, 7, 0, 16, 25, 20};
        vt[3] = '{0, 0, 1, 16, 1, 0, 16, 0, 15};
        vt[4] = '{140, 100, 16, 16, 6, 0, 256, 155, 115};
        vt[5] = '{5, 9, 3, 3, 0, 1, 19200, 159, 119};
        vt[6] = '{30, 30, 3, 0, 4, 0, 0, 0, 0};
        vt[7] = '{159, 119, 1, 1, 6, 0, 1, 159, 119};
`ifdef SPRITE_DRAW_CLIP_EN
        vt[8] = '{158, 118, 4, 4, 5, 0, 4, 159, 119};
        vt[9] = '{250, 126, 8, 4, 3, 0, 0, 0, 0};
`else
        vt[8] = '{158, 118, 4, 4, 5, 0, 16, 161, 121};
        vt[9] = '{250, 126, 8, 4, 3, 0, 32, 1, 1};
`endif

        reset = 1'b1;
        req_valid = 1'b0;
        req_clear = 1'b0;
        req_x = '0;
        req_y = '0;
        req_w = '0;
        req_h = '0;
        req_colour = '0;
        tick();
        tick();
        chk("reset_state", {10'b0, req_ready, plot, busy, done, x, y, colour},
            {10'b0, 4'b0000, 8'd0, 7'd0, 3'd0});
        reset = 1'b0;
        tick();
        chk("ready_after_reset", {30'b0, req_ready, busy}, {30'b0, 2'b10});

        for (int i = 0; i < 10; i++) begin
            issue(vt[i].px, vt[i].py, vt[i].w, vt[i].h, vt[i].col, vt[i].clr);
            if (vt[i].clr != 0)
                expect_stream(0, 0, 160, 120, vt[i].col, vt[i].n, vt[i].lx, vt[i].ly);
            else
                expect_stream(vt[i].px, vt[i].py, vt[i].w, vt[i].h, vt[i].col,
                              vt[i].n, vt[i].lx, vt[i].ly);
        end

        // Reset on the 5th pixel of a 4x4 draw aborts it with no done pulse.
        issue(20, 30, 4, 4, 2, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("fifth_pixel", {16'b0, plot, x, y}, {16'b0, 1'b1, 8'd20, 7'd31});
        reset = 1'b1;
        tick();
        chk("abort_reset", {28'b0, plot, done, busy, req_ready}, {28'b0, 4'b0000});
        reset = 1'b0;
        tick();
        chk("abort_idle", {28'b0, plot, done, busy, req_ready}, {28'b0, 4'b0001});
        tick();
        chk("abort_no_done", {30'b0, done, plot}, {30'b0, 2'b00});
        issue(1, 2, 2, 2, 5, 0);
        expect_stream(1, 2, 2, 2, 5, 4, 2, 3);

        // Valid held through a draw with a new payload: only taken once ready returns.
        issue(40, 40, 2, 2, 3, 0);
        req_valid = 1'b1;
        req_x = 8'd60;
        req_y = 7'd10;
        req_w = 5'd3;
        req_h = 5'd1;
        req_colour = 3'd4;
        expect_stream(40, 40, 2, 2, 3, 4, 41, 41);
        tick();
        req_valid = 1'b0;
        expect_stream(60, 10, 3, 1, 4, 3, 62, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
